rx_packet_decoder: RTL

RX_PACKET_DECODER -- requirements
Module: rx_packet_decoder

---
 rtl/usb_rx_pkg.sv | 48 ++++
 rtl/rx_crc16_checker.sv | 46 ++++
 rtl/rx_packet_decoder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB-style RX packet decoder.
package usb_rx_pkg;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;
  localparam logic [3:0] PidData  = 4'b0011;

  localparam logic [7:0] SyncByte = 8'b1000_0000;

  localparam int unsigned MaxPayload = 64;
  localparam int unsigned CrcBytes   = 2;

  localparam logic [15:0] CrcInit     = 16'hFFFF;
  localparam logic [15:0] CrcPoly     = 16'h8005;
  localparam logic [15:0] CrcResidual = 16'h800D;

  typedef enum logic [1:0] {
    StIdle,
    StPid,
    StPayload,
    StErr
  } rx_state_e;

  // Upper nibble must be the complement of the code, and the code must be known.
  function automatic logic pid_is_valid(logic [7:0] pid_byte);
    logic known;
    case (pid_byte[3:0])
      PidOut, PidIn, PidAck, PidNak, PidStall, PidData: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known && (pid_byte[7:4] == ~pid_byte[3:0]);
  endfunction

  // Payload length rule per PID; cnt counts every byte after the PID, CRC included.
  function automatic logic pid_len_ok(logic [3:0] pid, logic [6:0] cnt);
    logic ok;
    case (pid)
      PidOut, PidIn: ok = (cnt == 7'd2);
      PidData:       ok = (cnt >= 7'(CrcBytes)) && (cnt <= 7'(MaxPayload + CrcBytes));
      default:       ok = (cnt == 7'd0);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rx_crc16_checker.sv
// CRC16 over received payload bytes, bit 0 first. Only instantiated when
// RX_CRC16_CHECK_EN is defined.
module rx_crc16_checker
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] residual_o
);

  logic [15:0] crc_q, crc_d, crc_byte;

  // Fold one byte into the running CRC, LSB first.
  always_comb begin
    crc_byte = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (byte_i[i] ^ crc_byte[15]) begin
        crc_byte = {crc_byte[14:0], 1'b0} ^ CrcPoly;
      end else begin
        crc_byte = {crc_byte[14:0], 1'b0};
      end
    end
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CrcInit;
    end else if (byte_valid_i) begin
      crc_d = crc_byte;
    end
  end

  // Residual includes a byte arriving in the same cycle as eop.
  assign residual_o = byte_valid_i ? crc_byte : crc_q;

  // CRC register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_q <= CrcInit;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/rx_packet_decoder.sv
// RX packet decoder: sync/PID/payload framing, DATA payload extraction through a
// 2-byte delay buffer that withholds the trailing CRC. Optional CRC16 residual
// check is enabled with the RX_CRC16_CHECK_EN macro.
module rx_packet_decoder
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       byte_valid,
  input  logic [7:0] rx_byte,
  input  logic       eop,
  output logic [3:0] rx_packet,
  output logic       rx_packet_valid,
  output logic       store_rx_data,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       rx_error,
  output logic       rx_transfer_active,
  output logic [6:0] data_count
);

  rx_state_e  state_q;
  logic [3:0] rx_packet_q;
  logic       rx_packet_valid_q, store_rx_data_q, rx_data_ready_q;
  logic       rx_error_q, rx_transfer_active_q;
  logic [7:0] rx_data_q;
  logic [6:0] data_count_q;
  logic [6:0] pay_cnt_q;
  logic [7:0] buf_old_q, buf_new_q;
  logic [1:0] buf_cnt_q;

  logic       sync_hit, is_data, overflow, crc_feed, crc_ok;
  logic [6:0] pay_cnt_nxt;

  // Decode helpers shared by the FSM and the CRC checker.
  always_comb begin
    sync_hit = (state_q == StIdle) && byte_valid && (rx_byte == SyncByte);
    is_data  = (rx_packet_q == PidData);
    crc_feed = (state_q == StPayload) && byte_valid && is_data;
    overflow = crc_feed && (pay_cnt_q == 7'(MaxPayload + CrcBytes));
    pay_cnt_nxt = pay_cnt_q;
    if (byte_valid && (pay_cnt_q != 7'h7F)) begin
      pay_cnt_nxt = pay_cnt_q + 7'd1;
    end
  end

`ifdef RX_CRC16_CHECK_EN
  logic [15:0] crc_residual;

  rx_crc16_checker u_crc (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear_i     (sync_hit),
    .byte_valid_i(crc_feed),
    .byte_i      (rx_byte),
    .residual_o  (crc_residual)
  );

  assign crc_ok = !is_data || (crc_residual == CrcResidual);
`else
  assign crc_ok = 1'b1;
`endif

  // Packet FSM with registered outputs. A byte and eop in the same cycle are
  // handled byte first, so an error raised by that byte also ends the packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q              <= StIdle;
      rx_packet_q          <= 4'd0;
      rx_packet_valid_q    <= 1'b0;
      store_rx_data_q      <= 1'b0;
      rx_data_q            <= 8'd0;
      rx_data_ready_q      <= 1'b0;
      rx_error_q           <= 1'b0;
      rx_transfer_active_q <= 1'b0;
      data_count_q         <= 7'd0;
      pay_cnt_q            <= 7'd0;
      buf_old_q            <= 8'd0;
      buf_new_q            <= 8'd0;
      buf_cnt_q            <= 2'd0;
    end else begin
      rx_packet_valid_q <= 1'b0;
      store_rx_data_q   <= 1'b0;
      rx_data_ready_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sync_hit) begin
            state_q              <= StPid;
            rx_error_q           <= 1'b0;
            rx_transfer_active_q <= 1'b1;
            data_count_q         <= 7'd0;
            pay_cnt_q            <= 7'd0;
            buf_cnt_q            <= 2'd0;
          end
        end
        StPid: begin
          if (byte_valid && pid_is_valid(rx_byte)) begin
            rx_packet_q       <= rx_byte[3:0];
            rx_packet_valid_q <= 1'b1;
            if (eop) begin
              state_q              <= StIdle;
              rx_transfer_active_q <= 1'b0;
              if (!pid_len_ok(rx_byte[3:0], 7'd0)) rx_error_q <= 1'b1;
            end else begin
              state_q <= StPayload;
            end
          end else if (byte_valid || eop) begin
            rx_error_q <= 1'b1;
            if (eop) begin
              state_q              <= StIdle;
              rx_transfer_active_q <= 1'b0;
            end else begin
              state_q <= StErr;
            end
          end
        end
        StPayload: begin
          if (overflow) begin
            rx_error_q <= 1'b1;
            if (eop) begin
              state_q              <= StIdle;
              rx_transfer_active_q <= 1'b0;
            end else begin
              state_q <= StErr;
            end
          end else begin
            if (byte_valid) begin
              pay_cnt_q <= pay_cnt_nxt;
              if (is_data) begin
                if (buf_cnt_q == 2'd2) begin
                  store_rx_data_q <= 1'b1;
                  rx_data_q       <= buf_old_q;
                  data_count_q    <= data_count_q + 7'd1;
                  buf_old_q       <= buf_new_q;
                  buf_new_q       <= rx_byte;
                end else if (buf_cnt_q == 2'd1) begin
                  buf_new_q <= rx_byte;
                  buf_cnt_q <= 2'd2;
                end else begin
                  buf_old_q <= rx_byte;
                  buf_cnt_q <= 2'd1;
                end
              end
            end
            if (eop) begin
              state_q              <= StIdle;
              rx_transfer_active_q <= 1'b0;
              if (pid_len_ok(rx_packet_q, pay_cnt_nxt) && crc_ok) begin
                rx_data_ready_q <= is_data;
              end else begin
                rx_error_q <= 1'b1;
              end
            end
          end
        end
        StErr: begin
          if (eop) begin
            state_q              <= StIdle;
            rx_transfer_active_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_packet          = rx_packet_q;
  assign rx_packet_valid    = rx_packet_valid_q;
  assign store_rx_data      = store_rx_data_q;
  assign rx_data            = rx_data_q;
  assign rx_data_ready      = rx_data_ready_q;
  assign rx_error           = rx_error_q;
  assign rx_transfer_active = rx_transfer_active_q;
  assign data_count         = data_count_q;

endmodule
